// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, addresses and word type for the ARM register file
//
// Purpose : constants used by the register file top and its read muxes.
// Contents: DATA_W, ADDR_W, NUM_PHYS, PC_ADDR, word_t.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 9;
    localparam int NUM_PHYS = 15;
    localparam int PC_ADDR  = 15;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_read_mux.sv
// rtl/regfile_read_mux.sv - combinational read port decode for the ARM register file
//
// Purpose : selects stored data, the external R15 value, or zero for one read address.
// Ports   : addr  - read address (ADDR_W bits)
//           regs  - stored registers R0..R14
//           r15   - value returned for address 15 (PC+8)
//           rdata - selected read data
module regfile_read_mux
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  word_t             regs [NUM_PHYS],
    input  word_t             r15,
    output word_t             rdata
);

    always_comb begin
        rdata = '0;
        if (addr < ADDR_W'(NUM_PHYS)) begin
            // addr is below 15 here, so the low four bits are the full index
            rdata = regs[addr[3:0]];
        end else if (addr == ADDR_W'(PC_ADDR)) begin
            rdata = r15;
        end
    end

endmodule

// File: rtl/arm_register_file.sv
// rtl/arm_register_file.sv - ARM-style register file, two combinational reads, one clocked write
//
// Purpose : R0..R14 storage for the single-cycle core; address 15 reads the supplied PC+8.
// Ports   : clk      - clock, writes on rising edge
//           rst      - asynchronous active-high reset, clears R0..R14
//           A1, A2   - read addresses
//           A3       - write address
//           WD3      - write data
//           R15      - value returned for reads of address 15
//           WE3      - write enable
//           RD1, RD2 - read data
module arm_register_file
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  word_t             WD3,
    input  word_t             R15,
    input  logic              WE3,
    output word_t             RD1,
    output word_t             RD2
);

    word_t regs [NUM_PHYS];

    logic write_hit;

    // Address 15 and anything above the stored range are silently dropped.
    assign write_hit = WE3 && (A3 < ADDR_W'(NUM_PHYS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[A3[3:0]] <= WD3;
        end
    end

    // No write bypass: reads see storage, so a same-address write shows up after the edge.
    regfile_read_mux u_read_mux1 (
        .addr  (A1),
        .regs  (regs),
        .r15   (R15),
        .rdata (RD1)
    );

    regfile_read_mux u_read_mux2 (
        .addr  (A2),
        .regs  (regs),
        .r15   (R15),
        .rdata (RD2)
    );

endmodule

// File: tb/tb_arm_register_file.sv
// tb/tb_arm_register_file.sv - directed scoreboard bench for arm_register_file
module tb_arm_register_file;

    logic        clk;
    logic        rst;
    logic [8:0]  A1;
    logic [8:0]  A2;
    logic [8:0]  A3;
    logic [31:0] WD3;
    logic [31:0] R15;
    logic        WE3;
    logic [31:0] RD1;
    logic [31:0] RD2;

    int checks;
    int errors;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    arm_register_file dut (
        .clk (clk),
        .rst (rst),
        .A1  (A1),
        .A2  (A2),
        .A3  (A3),
        .WD3 (WD3),
        .R15 (R15),
        .WE3 (WE3),
        .RD1 (RD1),
        .RD2 (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] value);
        tag_q.push_back(tag);
        exp_q.push_back(value);
    endtask

    task automatic check(input logic [31:0] observed);
        logic [31:0] expected;
        string       tag;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed %h expected none", observed);
        end else begin
            expected = exp_q.pop_front();
            tag      = tag_q.pop_front();
            assert (observed === expected) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", tag, observed, expected);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        A1  = 9'd0;
        A2  = 9'd14;
        A3  = 9'd0;
        WD3 = 32'h0;
        R15 = 32'h0;
        WE3 = 1'b0;

        // reset state
        #2;
        expect_val("reset_rd1_r0", 32'h0);
        check(RD1);
        expect_val("reset_rd2_r14", 32'h0);
        check(RD2);
        tick();
        rst = 1'b0;

        // write with enable low
        WE3 = 1'b0; A3 = 9'd1; WD3 = 32'h12345678;
        tick();
        A1 = 9'd1;
        #1;
        expect_val("we_low_r1", 32'h0);
        check(RD1);

        // enabled write
        WE3 = 1'b1; A3 = 9'd2; WD3 = 32'h87654321;
        tick();
        WE3 = 1'b0; A2 = 9'd2;
        #1;
        expect_val("write_r2", 32'h87654321);
        check(RD2);
        expect_val("r1_still_zero", 32'h0);
        check(RD1);

        // PC read follows R15 combinationally
        R15 = 32'h10; A1 = 9'd15;
        #1;
        expect_val("pc_read", 32'h10);
        check(RD1);
        R15 = 32'h14;
        #1;
        expect_val("pc_follow", 32'h14);
        check(RD1);

        // write to 15 is dropped
        WE3 = 1'b1; A3 = 9'd15; WD3 = 32'hDEADBEEF;
        tick();
        WE3 = 1'b0; R15 = 32'h10; A1 = 9'd15;
        #1;
        expect_val("write15_ignored", 32'h10);
        check(RD1);

        // out-of-range write is dropped and must not alias onto R0
        WE3 = 1'b1; A3 = 9'h020; WD3 = 32'h55AA55AA;
        tick();
        WE3 = 1'b0; A1 = 9'h020; A2 = 9'd0;
        #1;
        expect_val("oor_read", 32'h0);
        check(RD1);
        expect_val("oor_no_alias_r0", 32'h0);
        check(RD2);
        A1 = 9'h1FF;
        #1;
        expect_val("oor_read_max", 32'h0);
        check(RD1);

        // highest stored register
        WE3 = 1'b1; A3 = 9'd14; WD3 = 32'hCAFEF00D;
        tick();
        WE3 = 1'b0; A2 = 9'd14;
        #1;
        expect_val("write_r14", 32'hCAFEF00D);
        check(RD2);

        // dual read of the same register
        WE3 = 1'b1; A3 = 9'd3; WD3 = 32'h11112222;
        tick();
        WE3 = 1'b0; A1 = 9'd3; A2 = 9'd3;
        #1;
        expect_val("dual_rd1", 32'h11112222);
        check(RD1);
        expect_val("dual_rd2", 32'h11112222);
        check(RD2);

        // read during write: old value before the edge, new value after
        WE3 = 1'b1; A3 = 9'd3; WD3 = 32'hA5A5A5A5;
        #1;
        expect_val("rdw_before", 32'h11112222);
        check(RD1);
        tick();
        WE3 = 1'b0;
        expect_val("rdw_after", 32'hA5A5A5A5);
        check(RD1);

        // asynchronous reset between edges
        A2 = 9'd2; A1 = 9'd14;
        #1;
        expect_val("pre_reset_r2", 32'h87654321);
        check(RD2);
        #1;
        rst = 1'b1;
        #1;
        expect_val("async_reset_r2", 32'h0);
        check(RD2);
        expect_val("async_reset_r14", 32'h0);
        check(RD1);

        // writes blocked while reset held
        WE3 = 1'b1; A3 = 9'd2; WD3 = 32'h1;
        tick();
        expect_val("reset_blocks_write", 32'h0);
        check(RD2);
        A1 = 9'd15; R15 = 32'h20;
        #1;
        expect_val("reset_pc_read", 32'h20);
        check(RD1);

        // release reset, storage remains cleared
        WE3 = 1'b0;
        rst = 1'b0;
        tick();
        expect_val("post_reset_r2", 32'h0);
        check(RD2);

        // sweep: write each stored register, read back on both ports
        for (int i = 0; i < 15; i++) begin
            WE3 = 1'b1; A3 = 9'(i); WD3 = 32'h1000_0000 + 32'(i * 32'h0101_0101);
            tick();
        end
        WE3 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            A1 = 9'(i); A2 = 9'(14 - i);
            #1;
            expect_val("sweep_rd1", 32'h1000_0000 + 32'(i * 32'h0101_0101));
            check(RD1);
            expect_val("sweep_rd2", 32'h1000_0000 + 32'((14 - i) * 32'h0101_0101));
            check(RD2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_register_file.md
Name: arm_register_file

Overview:
- ARM-style integer register file for the single-cycle core datapath.
- Provides two combinational read ports (RD1, RD2) and one clocked write port (A3/WD3/WE3).
- Physical storage covers R0–R14. Address 15 is not stored; reading it returns the externally supplied R15 value (PC+8 from the fetch stage).
- Sits between the instruction decode and ALU stages.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 9, width of the A1/A2/A3 address ports; only addresses 0–15 are architecturally valid.
- NUM_PHYS, 15, number of stored registers (R0–R14).
- PC_ADDR, 15, address that returns the R15 input instead of stored data.

Ports:
- clk  input  1  system clock; writes occur on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all stored registers.
- A1  input  ADDR_W  read address, port 1.
- A2  input  ADDR_W  read address, port 2.
- A3  input  ADDR_W  write address.
- WD3  input  DATA_W  write data.
- R15  input  DATA_W  value returned for reads of address 15 (PC+8).
- WE3  input  1  write enable, active high.
- RD1  output  DATA_W  read data, port 1.
- RD2  output  DATA_W  read data, port 2.

Behaviour:
- Reset:
  - rst=1 asynchronously clears R0–R14 to 32'h0, independent of clk.
  - Registers hold 0 for as long as rst is high, and writes are blocked during reset.
  - RD1/RD2 for addresses 0–14 show 0 immediately (combinational path from the cleared storage).
  - Reads of address 15 still return R15 during reset.
- Write:
  - On the rising edge of clk with rst=0, WE3=1 and A3 in 0..14, reg[A3] <= WD3.
  - WE3=0: no register changes.
  - A3=15: write ignored (R15 is not stored).
  - A3>=16: write ignored.
- Read (purely combinational, zero latency, no clock involvement):
  - RDn = reg[An] when An in 0..14.
  - RDn = R15 when An == 15.
  - RDn = 32'h0 when An >= 16.
- Both read ports are independent and may address the same register simultaneously.
- Read-during-write to the same address:
  - No bypass. RD shows the old value until the clock edge and the new value right after it, within the same delta-settled cycle.
- R15 input changes propagate combinationally to any port currently reading address 15.
- Storage contents are undefined before the first reset; the bench must apply rst or rely on 0 initialization. The implementation must initialize storage to 0 at time zero for simulation.
- No X propagation on outputs for any in-range or out-of-range address once reset has been applied.

Decomposition:
- Shared package, regfile_pkg, holds DATA_W, ADDR_W, NUM_PHYS, PC_ADDR and a typedef word_t = logic [DATA_W-1:0].
- A read-mux function (address decode, including the 15 and out-of-range cases) is used twice. Implement it as a function inside the module, or as one small sub-module, regfile_read_mux, instantiated once per read port.
- The storage array and write logic remain in the top module.

Test Plan:
- Write with enable low: WE3=0, A3=1, WD3=32'h12345678, one clock, then A1=1 -> RD1=32'h00000000.
- Enabled write: WE3=1, A3=2, WD3=32'h87654321, one clock, WE3=0, A2=2 -> RD2=32'h87654321; RD1 (A1=1) stays 0.
- PC read: R15=32'h00000010, A1=15 -> RD1=32'h00000010 combinationally. Change R15 to 32'h00000014 -> RD1 follows with no clock.
- Write to 15 and out of range:
  - WE3=1, A3=15, WD3=32'hDEADBEEF, one clock; R15=32'h10, A1=15 -> RD1=32'h10.
  - A3=9'h020 write, then read A1=9'h020 -> RD1=0.
  - Register 14 written with 32'hCAFEF00D reads back via A2=14 -> RD2=32'hCAFEF00D.
- Async reset mid-operation: with R2=32'h87654321 on RD2, assert rst between clock edges -> RD2=0 immediately.
  - While rst=1, WE3=1, A3=2, WD3=32'h1 across a clock edge -> RD2 remains 0.
  - During reset, A1=15 still returns R15.
- Same-address dual read and read-during-write:
  - A1=A2=3 -> RD1 and RD2 both equal reg[3].
  - Write A3=3, WD3=32'hA5A5A5A5 -> RD1 shows the old value before the edge and 32'hA5A5A5A5 after it.
